// File: rtl/decrypt_loop_if.sv
// Memory-side bus of the RC4 keystream/XOR stage.
// The bus has three ports:
//   - S-memory read/write port;
//   - encrypted-message ROM read port;
//   - decrypted-message RAM write port.
interface decrypt_loop_if;
  logic [7:0] s_address;
  logic [7:0] s_data;
  logic       s_wren;
  logic [7:0] s_data_read;
  logic [4:0] rom_address;
  logic [7:0] rom_data_read;
  logic [4:0] ram_address;
  logic [7:0] ram_data;
  logic       ram_wren;

  // Decrypt engine side: drives addresses/write data, receives read data
  modport master (
    output s_address, s_data, s_wren, rom_address, ram_address, ram_data, ram_wren,
    input  s_data_read, rom_data_read
  );

  // Memory side: receives addresses/write data, returns read data
  modport slave (
    input  s_address, s_data, s_wren, rom_address, ram_address, ram_data, ram_wren,
    output s_data_read, rom_data_read
  );
endinterface

// File: rtl/decrypt_loop.sv
// RC4 keystream generation and XOR decryption over S[0..255] left by the key
// schedule. Each message byte takes 15 cycles.
//
// Handshake:
//   - start_flag is a level request: while it is high the engine runs.
//   - done_flag is a level acknowledge, held in FINISH until start_flag drops.
//   - Dropping start_flag in any state returns to IDLE with everything cleared
//     on the next edge.
//
// Memories: the address is driven in a READ state and the data is sampled in
// the SAVE state three cycles later. Addresses are held through the wait states.
module decrypt_loop #(
  parameter int MSG_LEN     = 32,
  parameter bit CHECK_ASCII = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_flag,
  output logic           done_flag,
  output logic           key_bad,
  output logic [4:0]     state_dbg,
  decrypt_loop_if.master mem
);

  typedef enum logic [4:0] {
    IDLE, READ_I, WAIT_I1, WAIT_I2, SAVE_I, READ_J, WAIT_J1, WAIT_J2, SAVE_J,
    WRITE_I, WRITE_J, READ_F, WAIT_F1, WAIT_F2, SAVE_F, WRITE_OUT, FINISH
  } state_t;

  localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [7:0] si_q, si_d, sj_q, sj_d, f_q, f_d, c_q, c_d;
  logic [7:0] s_address_q, s_address_d, s_data_q, s_data_d;
  logic       s_wren_q, s_wren_d;
  logic [4:0] rom_address_q, rom_address_d, ram_address_q, ram_address_d;
  logic [7:0] ram_data_q, ram_data_d;
  logic       ram_wren_q, ram_wren_d, done_q, done_d, key_bad_q, key_bad_d;
  logic [7:0] plain;
  logic [7:0] fresh_plain;

  // Printable plaintext: space or lowercase letter
  function automatic logic ascii_ok(input logic [7:0] b);
    return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
  endfunction

  assign plain       = f_q ^ c_q;
  assign fresh_plain = mem.s_data_read ^ mem.rom_data_read;

  // Next-state and next-output logic; outputs are registered for the state entered
  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    si_d          = si_q;
    sj_d          = sj_q;
    f_d           = f_q;
    c_d           = c_q;
    s_address_d   = s_address_q;
    s_data_d      = s_data_q;
    s_wren_d      = 1'b0;
    rom_address_d = rom_address_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    done_d        = 1'b0;
    key_bad_d     = key_bad_q;
    if (!start_flag) begin
      state_d       = IDLE;
      i_d           = '0;
      j_d           = '0;
      k_d           = '0;
      si_d          = '0;
      sj_d          = '0;
      f_d           = '0;
      c_d           = '0;
      s_address_d   = '0;
      s_data_d      = '0;
      rom_address_d = '0;
      ram_address_d = '0;
      ram_data_d    = '0;
      key_bad_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d     = READ_I;
          i_d         = i_q + 8'd1;
          s_address_d = i_q + 8'd1;
        end
        READ_I:  state_d = WAIT_I1;
        WAIT_I1: state_d = WAIT_I2;
        WAIT_I2: state_d = SAVE_I;
        SAVE_I: begin
          // j advances by the value just read, not by any older register
          state_d     = READ_J;
          si_d        = mem.s_data_read;
          j_d         = j_q + mem.s_data_read;
          s_address_d = j_q + mem.s_data_read;
        end
        READ_J:  state_d = WAIT_J1;
        WAIT_J1: state_d = WAIT_J2;
        WAIT_J2: state_d = SAVE_J;
        SAVE_J: begin
          state_d     = WRITE_I;
          sj_d        = mem.s_data_read;
          s_address_d = i_q;
          s_data_d    = mem.s_data_read;
          s_wren_d    = 1'b1;
        end
        WRITE_I: begin
          // When i==j this second write lands on the same address, leaving S[i]=si
          state_d     = WRITE_J;
          s_address_d = j_q;
          s_data_d    = si_q;
          s_wren_d    = 1'b1;
        end
        WRITE_J: begin
          state_d       = READ_F;
          s_address_d   = si_q + sj_q;
          rom_address_d = k_q[4:0];
        end
        READ_F:  state_d = WAIT_F1;
        WAIT_F1: state_d = WAIT_F2;
        WAIT_F2: state_d = SAVE_F;
        SAVE_F: begin
          state_d       = WRITE_OUT;
          f_d           = mem.s_data_read;
          c_d           = mem.rom_data_read;
          ram_address_d = k_q[4:0];
          ram_data_d    = fresh_plain;
          ram_wren_d    = !CHECK_ASCII || ascii_ok(fresh_plain);
        end
        WRITE_OUT: begin
          if (CHECK_ASCII && !ascii_ok(plain)) begin
            state_d   = FINISH;
            key_bad_d = 1'b1;
            done_d    = 1'b1;
          end else if (k_q == LAST_K) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d     = READ_I;
            k_d         = k_q + 8'd1;
            i_d         = i_q + 8'd1;
            s_address_d = i_q + 8'd1;
          end
        end
        FINISH:  done_d  = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      i_q           <= '0;
      j_q           <= '0;
      k_q           <= '0;
      si_q          <= '0;
      sj_q          <= '0;
      f_q           <= '0;
      c_q           <= '0;
      s_address_q   <= '0;
      s_data_q      <= '0;
      s_wren_q      <= 1'b0;
      rom_address_q <= '0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      done_q        <= 1'b0;
      key_bad_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      j_q           <= j_d;
      k_q           <= k_d;
      si_q          <= si_d;
      sj_q          <= sj_d;
      f_q           <= f_d;
      c_q           <= c_d;
      s_address_q   <= s_address_d;
      s_data_q      <= s_data_d;
      s_wren_q      <= s_wren_d;
      rom_address_q <= rom_address_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      done_q        <= done_d;
      key_bad_q     <= key_bad_d;
    end
  end

  assign mem.s_address   = s_address_q;
  assign mem.s_data      = s_data_q;
  assign mem.s_wren      = s_wren_q;
  assign mem.rom_address = rom_address_q;
  assign mem.ram_address = ram_address_q;
  assign mem.ram_data    = ram_data_q;
  assign mem.ram_wren    = ram_wren_q;
  assign done_flag       = done_q;
  assign key_bad         = key_bad_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_decrypt_loop.sv
// Bench for decrypt_loop. The three instances are configured as follows:
//   - instance 0: MSG_LEN=2,  no ASCII check;
//   - instance 1: MSG_LEN=2,  ASCII check;
//   - instance 2: MSG_LEN=32, no ASCII check.
// Each instance has its own S memory, ROM and RAM with registered reads.
module tb_decrypt_loop;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v   [NI];
  logic       start_v [NI];
  logic       load_v  [NI];
  logic [7:0] s_rd_v  [NI];
  logic [7:0] rom_rd_v[NI];
  wire  [7:0] s_addr_v   [NI];
  wire  [7:0] s_wdata_v  [NI];
  wire        s_wren_v   [NI];
  wire  [4:0] rom_addr_v [NI];
  wire  [4:0] ram_addr_v [NI];
  wire  [7:0] ram_data_v [NI];
  wire        ram_wren_v [NI];
  wire        done_v     [NI];
  wire        kbad_v     [NI];
  wire  [4:0] st_v       [NI];

  logic [7:0] s_mem   [NI][256];
  logic [7:0] s_init  [NI][256];
  logic [7:0] rom_mem [NI][32];
  logic [7:0] rom_init[NI][32];
  logic [7:0] ram_mem [NI][32];

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LEN = (g == 2) ? 32 : 2;
    localparam bit CHK = (g == 1);
    decrypt_loop_if bus ();
    assign bus.s_data_read   = s_rd_v[g];
    assign bus.rom_data_read = rom_rd_v[g];
    assign s_addr_v[g]       = bus.s_address;
    assign s_wdata_v[g]      = bus.s_data;
    assign s_wren_v[g]       = bus.s_wren;
    assign rom_addr_v[g]     = bus.rom_address;
    assign ram_addr_v[g]     = bus.ram_address;
    assign ram_data_v[g]     = bus.ram_data;
    assign ram_wren_v[g]     = bus.ram_wren;
    decrypt_loop #(.MSG_LEN(LEN), .CHECK_ASCII(CHK)) u_dut (
      .clk       (clk),
      .reset     (rst_v[g]),
      .start_flag(start_v[g]),
      .done_flag (done_v[g]),
      .key_bad   (kbad_v[g]),
      .state_dbg (st_v[g]),
      .mem       (bus)
    );
  end

  // Memories: one-cycle registered read, address held by the DUT until SAVE
  always @(posedge clk) begin
    for (int n = 0; n < NI; n++) begin
      if (load_v[n]) begin
        for (int x = 0; x < 256; x++) s_mem[n][x] <= s_init[n][x];
        for (int x = 0; x < 32; x++) begin
          rom_mem[n][x] <= rom_init[n][x];
          ram_mem[n][x] <= 8'hEE;
        end
      end else begin
        s_rd_v[n]   <= s_mem[n][s_addr_v[n]];
        rom_rd_v[n] <= rom_mem[n][rom_addr_v[n]];
        if (s_wren_v[n])   s_mem[n][s_addr_v[n]]     <= s_wdata_v[n];
        if (ram_wren_v[n]) ram_mem[n][ram_addr_v[n]] <= ram_data_v[n];
      end
    end
  end

  // Scoreboard
  int vectors     = 0;
  int miscompares = 0;
  int act         = 0;
  logic [15:0] exp_s_q [$];
  logic [15:0] exp_r_q [$];
  logic [7:0]  m_s   [256];
  logic [7:0]  m_ram [32];
  int          m_bytes;
  logic        m_bad;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Software RC4 PRGA from the current memory contents
  task automatic run_model(input int n, input int len, input bit chk);
    logic [7:0] i, j, si, sj, t, p;
    i = 8'd0;
    j = 8'd0;
    m_bad = 1'b0;
    m_bytes = 0;
    for (int x = 0; x < 256; x++) m_s[x] = s_mem[n][x];
    for (int x = 0; x < 32; x++) m_ram[x] = ram_mem[n][x];
    exp_s_q.delete();
    exp_r_q.delete();
    for (int k = 0; k < len && !m_bad; k++) begin
      i = i + 8'd1;
      j = j + m_s[i];
      si = m_s[i];
      sj = m_s[j];
      m_s[i] = sj;
      exp_s_q.push_back({i, sj});
      m_s[j] = si;
      exp_s_q.push_back({j, si});
      t = si + sj;
      p = m_s[t] ^ rom_mem[n][k];
      m_bytes = k + 1;
      if (chk && !(p == 8'h20 || (p >= 8'h61 && p <= 8'h7A))) m_bad = 1'b1;
      else begin
        m_ram[k] = p;
        exp_r_q.push_back({3'b000, 5'(k), p});
      end
    end
  endtask

  // Compare process: every write the active instance makes must be the next expected one
  always @(negedge clk) begin
    logic [15:0] e;
    if (s_wren_v[act] === 1'b1) begin
      if (exp_s_q.size() == 0) check("s_write_unexpected", {s_addr_v[act], s_wdata_v[act]}, 64'hFFFF_FFFF);
      else begin
        e = exp_s_q.pop_front();
        check("s_write", {s_addr_v[act], s_wdata_v[act]}, e);
      end
    end
    if (ram_wren_v[act] === 1'b1) begin
      if (exp_r_q.size() == 0) check("ram_write_unexpected", {ram_addr_v[act], ram_data_v[act]}, 64'hFFFF_FFFF);
      else begin
        e = exp_r_q.pop_front();
        check("ram_write", {3'b000, ram_addr_v[act], ram_data_v[act]}, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n);
    load_v[n] = 1'b1;
    tick();
    load_v[n] = 1'b0;
  endtask

  task automatic idle_zero(input int n, input string tag);
    check({tag, " outs_a"}, {st_v[n], s_addr_v[n], s_wdata_v[n], s_wren_v[n]}, 64'd0);
    check({tag, " outs_b"}, {rom_addr_v[n], ram_addr_v[n], ram_data_v[n], ram_wren_v[n],
                             done_v[n], kbad_v[n]}, 64'd0);
  endtask

  task automatic run_to_done(input int n, input int len, input string tag);
    int cyc;
    int bad;
    act = n;
    start_v[n] = 1'b1;
    tick();
    cyc = 0;
    while (done_v[n] !== 1'b1 && cyc < 2000) begin
      tick();
      cyc++;
    end
    check({tag, " done_cycles"}, cyc, 15 * m_bytes);
    check({tag, " key_bad"}, kbad_v[n], m_bad);
    tick();
    check({tag, " done_held"}, {done_v[n], kbad_v[n]}, {1'b1, m_bad});
    check({tag, " s_writes_left"}, exp_s_q.size(), 0);
    check({tag, " ram_writes_left"}, exp_r_q.size(), 0);
    for (int x = 0; x < len; x++)
      check($sformatf("%s ram[%0d]", tag, x), ram_mem[n][x], m_ram[x]);
    bad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[n][x] !== m_s[x]) bad++;
    check({tag, " s_final_bad_entries"}, bad, 0);
    start_v[n] = 1'b0;
    tick();
    idle_zero(n, {tag, " after_stop"});
  endtask

  initial begin
    for (int n = 0; n < NI; n++) begin
      rst_v[n] = 1'b1;
      start_v[n] = 1'b0;
      load_v[n] = 1'b0;
      for (int x = 0; x < 256; x++) s_init[n][x] = 8'(x);
      for (int x = 0; x < 32; x++) rom_init[n][x] = 8'h00;
    end
    repeat (3) tick();
    for (int n = 0; n < NI; n++) idle_zero(n, "reset");
    for (int n = 0; n < NI; n++) rst_v[n] = 1'b0;

    // Identity S, no check: byte 0 has i==j==1
    rom_init[0][0] = 8'h61;
    rom_init[0][1] = 8'h60;
    load(0);
    run_model(0, 2, 1'b0);
    check("pin ident s_wr0", exp_s_q[0], 16'h0101);
    check("pin ident s_wr1", exp_s_q[1], 16'h0101);
    check("pin ident ram0", m_ram[0], 8'h63);
    check("pin ident ram1", m_ram[1], 8'h65);
    check("pin ident s2_s3", {m_s[2], m_s[3]}, 16'h0302);
    run_to_done(0, 2, "ident");
    check("ident ram0 literal", ram_mem[0][0], 8'h63);
    check("ident ram1 literal", ram_mem[0][1], 8'h65);

    // ASCII check: plaintext 0x02 rejected at byte 0
    rom_init[1][0] = 8'h00;
    rom_init[1][1] = 8'h60;
    load(1);
    run_model(1, 2, 1'b1);
    check("pin bad0 flags", {m_bad, 8'(m_bytes)}, {1'b1, 8'd1});
    run_to_done(1, 2, "bad0");
    check("bad0 ram0 unwritten", ram_mem[1][0], 8'hEE);

    // ASCII check: 0x63 then 0x7A (upper bound) both accepted
    rom_init[1][0] = 8'h61;
    rom_init[1][1] = 8'h7F;
    load(1);
    run_model(1, 2, 1'b1);
    check("pin ok7a flags", {m_bad, m_ram[1]}, {1'b0, 8'h7A});
    run_to_done(1, 2, "ok7a");

    // ASCII check: 0x7B just above range rejected at byte 1
    rom_init[1][1] = 8'h7E;
    load(1);
    run_model(1, 2, 1'b1);
    check("pin bad7b flags", {m_bad, 8'(m_bytes)}, {1'b1, 8'd2});
    run_to_done(1, 2, "bad7b");

    // Random permutation, random ciphertext, 32 bytes
    for (int x = 255; x > 0; x--) begin
      int r;
      logic [7:0] tmp;
      r = $urandom_range(x, 0);
      tmp = s_init[2][x];
      s_init[2][x] = s_init[2][r];
      s_init[2][r] = tmp;
    end
    for (int x = 0; x < 32; x++) rom_init[2][x] = 8'($urandom_range(255, 0));
    load(2);
    run_model(2, 32, 1'b0);
    run_to_done(2, 32, "rand");

    // Abort at WAIT_J1 of byte 5, then restart from scratch
    load(2);
    run_model(2, 32, 1'b0);
    act = 2;
    start_v[2] = 1'b1;
    tick();
    repeat (15 * 5 + 5) tick();
    check("abort s_writes_left", exp_s_q.size(), 64 - 10);
    check("abort ram_writes_left", exp_r_q.size(), 32 - 5);
    start_v[2] = 1'b0;
    tick();
    idle_zero(2, "abort");
    run_model(2, 32, 1'b0);
    run_to_done(2, 32, "restart");

    // Reset during WRITE_I: WRITE_J must not follow
    load(2);
    run_model(2, 32, 1'b0);
    act = 2;
    start_v[2] = 1'b1;
    tick();
    repeat (8) tick();
    check("rst write_i wren", s_wren_v[2], 1'b1);
    rst_v[2] = 1'b1;
    tick();
    idle_zero(2, "rst_mid");
    check("rst s_writes_left", exp_s_q.size(), 63);
    start_v[2] = 1'b0;
    tick();
    rst_v[2] = 1'b0;
    tick();
    run_model(2, 32, 1'b0);
    run_to_done(2, 32, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
